fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline. Owns the PC, issues in-order requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small FIFO. Discards in-flight responses on a branch/jump redirect. Drives `tmpPC` / `tmpInstr` of the IF/ID pipeline register. Inserts a NOP whenever no valid instruction is available, because IF/ID captures every cycle.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: FIFO entries and credit limit for outstanding requests (power of two, ≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_gnt`  in  1  request accepted this cycle when `imem_req`=1.
- `imem_rvalid`  in  1  response valid; responses are in order, at least 1 cycle after gnt.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  branch/jump taken (from EX).
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored and forced to 0.
- `id_stall`  in  1  ID cannot accept this cycle; head entry is held.
- `if_valid`  out  1  head entry valid.
- `if_pc`  out  32  head PC; 0 when empty.
- `if_instr`  out  32  head instruction; 32'h0000_0013 (NOP) when empty.

## Operation
- State: `pc_q` (next address to issue), FIFO of {pc, instr}, `inflight` (live outstanding requests), `discard` (outstanding requests whose responses are to be dropped), FSM `{FETCH, FLUSH}`.
- Issue condition: state=FETCH && `fifo_count + inflight + discard < DEPTH`. When true, `imem_req`=1 and `imem_addr`=`pc_q`.
- Issued request (req && gnt): `pc_q += 4`; `inflight++`; the address is pushed into an internal PC tag queue.
- Response handling:
  - If `discard` > 0: decrement `discard`; data dropped.
  - Otherwise: push {tag pc, rdata} into FIFO; `inflight--`.
- Pop: `if_valid && !id_stall`. A slot freed by a pop is creditable the next cycle, not the same cycle.
- Redirect (`redirect_valid`=1), highest priority:
  - `pc_q <= {redirect_pc[31:2],2'b00}`; FIFO and tag queue cleared; pop suppressed.
  - `discard <= discard + inflight + (req&&gnt) - rvalid`; `inflight <= 0`.
  - A response arriving in the redirect cycle is dropped.
  - State → FLUSH if the new discard > 0, else FETCH.
  - A request granted in the redirect cycle carries the old PC and is counted as discard.
- FLUSH: no issue. Returns to FETCH the cycle after `discard` reaches 0. A second redirect in FLUSH updates `pc_q` only.
- Width rules: counters are `$clog2(DEPTH)+1` bits. Overflow is impossible under the credit rule; a response with no outstanding request is a protocol error. Flag it with an assertion; no recovery is required.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_instr`=NOP, state=FETCH, counters 0.
- First `imem_req`=1 in the first cycle after `rst` deasserts.
- Latency: gnt at cycle t, rvalid at t+k (k≥1) → `if_valid`=1 at t+k+1. FIFO outputs are registered; no combinational path from `imem_rdata` to `if_instr`.
- No combinational path from `redirect_valid` or `id_stall` to `imem_req`. Issue uses registered counts only.
- Throughput: 1 instr/cycle when k≤DEPTH-2 and no stall.
- Reset mid-operation: all state is cleared. Responses to pre-reset requests are outside this block's contract; the memory is reset together with this block.
- Simultaneous events:
  - redirect beats pop, push, and issue accounting as defined above.
  - push + pop on a full FIFO is legal only if the pop happens; the credit rule guarantees space.

## Structure
- Package `fetch_pkg`: `NOP_INSTR` = 32'h0000_0013; `fetch_state_e` {FETCH, FLUSH}; typedef `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_fifo`: synchronous FIFO, DEPTH entries, with push, pop, clear, count, and registered head. Instantiated twice: for the instruction queue and for the PC tag queue.

## Test plan
- Reset release, gnt always 1, k=1, no stall → addresses 0x0, 0x4, 0x8… on consecutive cycles; `if_pc`/`if_instr` stream matches memory; first `if_valid` 3 cycles after reset release.
- `id_stall`=1 for 6 cycles, then released → `imem_req` drops after DEPTH credits are used; head holds pc 0x0; stream resumes with no loss or duplication.
- Two requests in flight (0x10, 0x14), redirect to 0x103 → both responses dropped; FLUSH for 2 response cycles; next issue at 0x100; `if_pc` 0x100 follows.
- Redirect to 0x200 in the same cycle as gnt for 0x20 and rvalid for 0x1C → 0x1C dropped; 0x20 counted as discard; no 0x1C or 0x20 at output.
- `imem_gnt`=0 for 5 cycles → `imem_addr` held at same value; `if_valid` drains to 0 with NOP output; no PC skip.
- `rst` pulsed with 3 entries buffered and 1 in flight → next cycle `if_valid`=0, `if_instr`=NOP, `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // addi x0, x0, 0 -- presented to ID whenever no fetched word is available.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    FLUSH
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear. The head is read straight out of the
// storage registers, so it never depends combinationally on the push data.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       pushData,
  input  logic                   pop,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  // Storage write; entries beyond count are never observed.
  // NOTE: the storage array has no reset -- validity is tracked by count alone,
  // and leaving it unreset lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
  // NOTE: sequential state uses <= only, so every register here samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rdPtr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order
// requests to instruction memory, buffers returned words and drops
// responses that belong to the path abandoned by a redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

  fetch_state_e  stateQ;
  logic [31:0]   pcQ;
  logic [CW-1:0] inflightQ;
  logic [CW-1:0] discardQ;
  logic [CW-1:0] inflightNext;
  logic [CW-1:0] discardNext;
  logic [CW-1:0] instrCount;
  logic [CW-1:0] tagCount;
  logic [CW+1:0] creditUse;
  logic [31:0]   tagHead;
  logic          granted;
  logic          respPush;
  logic          popHead;
  fetch_entry_t  respEntry;
  fetch_entry_t  headEntry;

  // Every buffered word, live request and doomed request holds a credit;
  // only registered counts feed the issue decision.
  assign creditUse = (CW+2)'(instrCount) + (CW+2)'(inflightQ) + (CW+2)'(discardQ);
  assign imem_req  = !rst && (stateQ == FETCH) && (creditUse < (CW+2)'(DEPTH));
  assign imem_addr = pcQ;
  assign granted   = imem_req && imem_gnt;

  // Responses are kept only when nothing is pending discard and no redirect
  // is flushing the queues this cycle.
  assign respPush  = imem_rvalid && (discardQ == '0) && !redirect_valid;
  assign popHead   = if_valid && !id_stall && !redirect_valid;
  assign respEntry = '{pc: tagHead, instr: imem_rdata};

  // Address tags of live requests, consumed in order as responses are kept.
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) tagQueue (
    .clk      (clk),
    .rst      (rst),
    .push     (granted && !redirect_valid),
    .pushData (pcQ),
    .pop      (respPush),
    .clear    (redirect_valid),
    .count    (tagCount),
    .head     (tagHead)
  );

  // Returned instructions waiting for ID.
  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) instrQueue (
    .clk      (clk),
    .rst      (rst),
    .push     (respPush),
    .pushData (respEntry),
    .pop      (popHead),
    .clear    (redirect_valid),
    .count    (instrCount),
    .head     (headEntry)
  );

  assign if_valid = (instrCount != '0);
  assign if_pc    = if_valid ? headEntry.pc    : 32'h0;
  assign if_instr = if_valid ? headEntry.instr : NOP_INSTR;

  // Next outstanding-request counts; a redirect turns all live requests,
  // including one granted this cycle, into discards.
  // NOTE: both outputs get a default first so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    inflightNext = inflightQ;
    discardNext  = discardQ;
    if (redirect_valid) begin
      inflightNext = '0;
      discardNext  = discardQ + inflightQ + CW'(granted) - CW'(imem_rvalid);
    end else begin
      if (granted) inflightNext = inflightNext + CW'(1);
      if (imem_rvalid) begin
        if (discardQ != '0) discardNext  = discardQ - CW'(1);
        else                inflightNext = inflightNext - CW'(1);
      end
    end
  end

  // PC, counters and FETCH/FLUSH control.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= FETCH;
      pcQ       <= START_PC;
      inflightQ <= '0;
      discardQ  <= '0;
    end else begin
      inflightQ <= inflightNext;
      discardQ  <= discardNext;
      if (redirect_valid)  pcQ <= redirect_pc & ~32'h3;
      else if (granted)    pcQ <= pcQ + 32'd4;
      if (redirect_valid)  stateQ <= (discardNext != '0) ? FLUSH : FETCH;
      else if (stateQ == FLUSH && discardNext == '0) stateQ <= FETCH;
    end
  end

  // A response with nothing outstanding breaks the memory protocol.
  assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (inflightQ != '0 || discardQ != '0));

  // The tag queue must track exactly the live requests.
  assert property (@(posedge clk) disable iff (rst) tagCount == inflightQ);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order memory model whose
// grant and latency are controlled per scenario.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    pending[$];
  int          total;
  int          bad;
  int          cyc;
  int          lat;
  logic        gntOn;
  logic        rstNxt;
  logic        stallNxt;
  logic        redirNxt;
  logic [31:0] redirPcNxt;
  logic [31:0] expPc;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard the pop ending this cycle, then advance one clock and apply
  // the staged inputs plus the memory model for the new cycle.
  task automatic tick();
    if (rst) expPc = RESET_PC;
    else if (redirect_valid) expPc = redirect_pc & ~32'h3;
    else if (if_valid && !id_stall) begin
      check("stream_pc", if_pc, expPc);
      check("stream_instr", if_instr, memWord(expPc));
      expPc += 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    rst            = rstNxt;
    redirect_valid = redirNxt;
    redirect_pc    = redirPcNxt;
    redirNxt       = 1'b0;
    id_stall       = stallNxt;
    imem_gnt       = gntOn;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    if (rst) pending.delete();
    else if (pending.size() != 0 && pending[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(pending[0].addr);
      void'(pending.pop_front());
    end
    #1;
    if (!rst && imem_req && imem_gnt) pending.push_back('{addr: imem_addr, due: cyc + lat});
  endtask

  task automatic doReset();
    rstNxt = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    clk = 0; rst = 1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; id_stall = 0;
    total = 0; bad = 0; cyc = 0; lat = 1; gntOn = 1;
    rstNxt = 1; stallNxt = 0; redirNxt = 0; redirPcNxt = 0; expPc = RESET_PC;

    // Reset state
    doReset();
    check("rst_req", {31'b0, imem_req}, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'b0, if_valid}, 0);
    check("rst_pc", if_pc, 0);
    check("rst_instr", if_instr, NOP_INSTR);

    // Streaming with k=1, grant always on
    rstNxt = 0;
    tick();
    check("s_req0", {31'b0, imem_req}, 1);
    check("s_addr0", imem_addr, 32'h0);
    check("s_valid0", {31'b0, if_valid}, 0);
    tick();
    check("s_addr1", imem_addr, 32'h4);
    check("s_valid1", {31'b0, if_valid}, 0);
    tick();
    check("s_addr2", imem_addr, 32'h8);
    check("s_valid2", {31'b0, if_valid}, 1);
    check("s_pc2", if_pc, 32'h0);
    check("s_instr2", if_instr, memWord(32'h0));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("s_thru", {31'b0, imem_req}, 1);
    end

    // Stall for 6 cycles from reset release
    doReset();
    rstNxt = 0; stallNxt = 1;
    tick();
    repeat (3) tick();
    check("st_req3", {31'b0, imem_req}, 1);
    check("st_addr3", imem_addr, 32'hC);
    tick();
    check("st_req4", {31'b0, imem_req}, 0);
    tick();
    check("st_req5", {31'b0, imem_req}, 0);
    check("st_head", if_pc, 32'h0);
    stallNxt = 0;
    tick();
    check("st_req6", {31'b0, imem_req}, 0);
    tick();
    check("st_req7", {31'b0, imem_req}, 1);
    check("st_addr7", imem_addr, 32'h10);
    repeat (10) tick();

    // Redirect with two requests in flight, target misaligned
    gntOn = 0; lat = 4;
    doReset();
    rstNxt = 0;
    tick();
    tick();
    check("f_hold", imem_addr, 32'h0);
    redirNxt = 1; redirPcNxt = 32'h10;
    tick();
    gntOn = 1;
    tick();
    check("f_addr10", imem_addr, 32'h10);
    tick();
    check("f_addr14", imem_addr, 32'h14);
    gntOn = 0; redirNxt = 1; redirPcNxt = 32'h103;
    tick();
    check("f_addr18", imem_addr, 32'h18);
    gntOn = 1;
    tick();
    check("f_flush0", {31'b0, imem_req}, 0);
    tick();
    check("f_flush1", {31'b0, imem_req}, 0);
    tick();
    check("f_flush2", {31'b0, imem_req}, 0);
    tick();
    check("f_req", {31'b0, imem_req}, 1);
    check("f_addr100", imem_addr, 32'h100);
    for (int i = 0; i < 10 && !if_valid; i++) tick();
    check("f_first_pc", if_pc, 32'h100);
    repeat (6) tick();

    // Redirect coinciding with gnt for 0x20 and rvalid for 0x1C
    lat = 1;
    doReset();
    rstNxt = 0;
    tick();
    for (int i = 0; i < 20 && imem_addr != 32'h1C; i++) tick();
    check("r_reach", imem_addr, 32'h1C);
    redirNxt = 1; redirPcNxt = 32'h200;
    tick();
    check("r_addr20", imem_addr, 32'h20);
    check("r_req", {31'b0, imem_req}, 1);
    tick();
    check("r_flush", {31'b0, imem_req}, 0);
    tick();
    check("r_req200", {31'b0, imem_req}, 1);
    check("r_addr200", imem_addr, 32'h200);
    repeat (8) tick();

    // Grant withheld for 5 cycles
    doReset();
    rstNxt = 0;
    repeat (6) tick();
    gntOn = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("g_addr", imem_addr, 32'h18);
    end
    check("g_valid", {31'b0, if_valid}, 0);
    check("g_pc", if_pc, 32'h0);
    check("g_instr", if_instr, NOP_INSTR);
    gntOn = 1;
    repeat (8) tick();

    // Reset pulse with 3 buffered and 1 in flight
    doReset();
    rstNxt = 0; stallNxt = 1;
    repeat (4) tick();
    check("p_valid", {31'b0, if_valid}, 1);
    rstNxt = 1;
    tick();
    rstNxt = 0; stallNxt = 0;
    tick();
    check("p_valid0", {31'b0, if_valid}, 0);
    check("p_instr", if_instr, NOP_INSTR);
    check("p_addr", imem_addr, RESET_PC);
    check("p_req", {31'b0, imem_req}, 1);
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
